// File: rtl/std_gray_codec_pipe.sv
// Pipelined, back-pressurable Gray<->binary converter; mode bit travels with each transaction.
// Define STD_GRAY_CODEC_PIPE_STEP_CHECK_EN to add a sticky Gray-step (Hamming distance > 1) checker on decodes.
module std_gray_codec_pipe #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_mode,
    output logic [WIDTH-1:0] o_data,
    output logic             o_step_err
);
    localparam int LEVELS = $clog2(WIDTH);
    localparam int LDIV   = (LEVELS == 0) ? 1 : LEVELS;
    localparam int DW     = LATENCY * WIDTH;

    // Valid/ready contract: a transfer happens on any cycle where valid and ready
    // are both high; a presented output holds stable until it is taken.

    // Work done by stage s: encode lives entirely in stage 0; decode applies the
    // Kogge-Stone prefix-XOR levels mapped to this stage (level k -> k*LATENCY/L).
    function automatic logic [WIDTH-1:0] stage_fn(input logic [WIDTH-1:0] d,
                                                  input logic mode, input int s);
        logic [WIDTH-1:0] p;
        p = d;
        if (mode) begin
            if (s == 0) p = d ^ (d >> 1);
        end else begin
            for (int k = 0; k < LEVELS; k++) begin
                if ((k * LATENCY) / LDIV == s) p = p ^ (p >> (1 << k));
            end
        end
        return p;
    endfunction

    logic [LATENCY-1:0]            vld_q;
    logic [LATENCY-1:0]            mode_q;
    logic [LATENCY-1:0][WIDTH-1:0] data_q;
    logic [LATENCY-1:0]            prev_vld;
    logic [LATENCY-1:0]            prev_mode;
    logic [LATENCY-1:0][WIDTH-1:0] prev_data;
    logic [LATENCY-1:0][WIDTH-1:0] data_d;
    logic [LATENCY-1:0]            adv;

    // Each stage's source is the stage below it, with the input port below stage 0.
    assign prev_vld  = (vld_q << 1) | LATENCY'(i_valid);
    assign prev_mode = (mode_q << 1) | LATENCY'(i_mode);
    assign prev_data = (data_q << WIDTH) | DW'(i_data);

    // A stage advances when it is empty or everything above it advances.
    always_comb begin : adv_chain
        logic run;
        adv = '0;
        run = i_ready;
        for (int s = LATENCY - 1; s >= 0; s--) begin
            run    = !vld_q[s] || run;
            adv[s] = run;
        end
    end

    always_comb begin
        data_d = '0;
        for (int s = 0; s < LATENCY; s++) begin
            data_d[s] = stage_fn(prev_data[s], prev_mode[s], s);
        end
    end

    // Payload only moves with a valid source so an emptied stage keeps its last value.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_q  <= '0;
            mode_q <= '0;
            data_q <= '0;
        end else begin
            for (int s = 0; s < LATENCY; s++) begin
                if (adv[s]) begin
                    vld_q[s] <= prev_vld[s];
                    if (prev_vld[s]) begin
                        mode_q[s] <= prev_mode[s];
                        data_q[s] <= data_d[s];
                    end
                end
            end
        end
    end

    assign o_ready = adv[0];
    assign o_valid = vld_q[LATENCY-1];
    assign o_mode  = mode_q[LATENCY-1];
    assign o_data  = data_q[LATENCY-1];

`ifdef STD_GRAY_CODEC_PIPE_STEP_CHECK_EN
    logic [WIDTH-1:0] last_q;
    logic             seen_q;
    logic             err_q;
    logic             dec_acc;

    assign dec_acc = i_valid && adv[0] && !i_mode;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_q <= '0;
            seen_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (dec_acc) begin
            last_q <= i_data;
            seen_q <= 1'b1;
            if (seen_q && ($countones(i_data ^ last_q) > 1)) err_q <= 1'b1;
        end
    end

    assign o_step_err = err_q;
`else
    assign o_step_err = 1'b0;
`endif

endmodule

// File: tb/tb_std_gray_codec_pipe.sv
// Self-checking bench for std_gray_codec_pipe: directed cases plus randomized streams
// scored against a behavioural Gray/binary model with an expected-output queue.
module tb_std_gray_codec_pipe;
    localparam int WIDTH   = 8;
    localparam int LATENCY = 2;
`ifdef STD_GRAY_CODEC_PIPE_STEP_CHECK_EN
    localparam logic STEP_EN = 1'b1;
`else
    localparam logic STEP_EN = 1'b0;
`endif

    logic             i_clk   = 1'b0;
    logic             i_rst   = 1'b1;
    logic             i_valid = 1'b0;
    logic             i_mode  = 1'b0;
    logic             i_ready = 1'b0;
    logic [WIDTH-1:0] i_data  = '0;
    logic             o_ready;
    logic             o_valid;
    logic             o_mode;
    logic [WIDTH-1:0] o_data;
    logic             o_step_err;

    int               n_checks   = 0;
    int               n_pass     = 0;
    int               n_out      = 0;
    logic             rand_ready = 1'b0;
    logic             exp_err    = 1'b0;
    logic [WIDTH:0]   exp_q[$];
`ifdef STD_GRAY_CODEC_PIPE_STEP_CHECK_EN
    logic [WIDTH-1:0] st_last = '0;
    logic             st_seen = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    std_gray_codec_pipe #(.WIDTH(WIDTH), .LATENCY(LATENCY)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_mode     (i_mode),
        .i_data     (i_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_mode     (o_mode),
        .o_data     (o_data),
        .o_step_err (o_step_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference: decoded bit k is the parity of all Gray bits at or above k.
    function automatic logic [WIDTH:0] model(input logic mode, input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        r = '0;
        if (mode) r = d ^ (d / 2);
        else for (int k = 0; k < WIDTH; k++) r[k] = ^(d >> k);
        return {mode, r};
    endfunction

    // ---------------- scoreboard / monitor ----------------
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'(o_valid), 32'd0);
                end else begin
                    check("out", 32'({o_mode, o_data}), 32'(exp_q[0]));
                    if (i_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
            check("step_err", 32'(o_step_err), 32'(exp_err));
            if (i_valid && o_ready) begin
                exp_q.push_back(model(i_mode, i_data));
`ifdef STD_GRAY_CODEC_PIPE_STEP_CHECK_EN
                if (!i_mode) begin
                    if (st_seen && $countones(i_data ^ st_last) > 1) exp_err = 1'b1;
                    st_last = i_data;
                    st_seen = 1'b1;
                end
`endif
            end
        end
    end

    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            if (rand_ready) i_ready = ($urandom_range(0, 1) == 1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        i_rst   = 1'b1;
        i_valid = 1'b0;
        #1;
        check("rst_o_valid", 32'(o_valid), 32'd0);
        exp_q.delete();
        exp_err = 1'b0;
`ifdef STD_GRAY_CODEC_PIPE_STEP_CHECK_EN
        st_seen = 1'b0;
        st_last = '0;
`endif
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_o_mode", 32'(o_mode), 32'd0);
        check("rst_o_data", 32'(o_data), 32'd0);
        check("rst_step_err", 32'(o_step_err), 32'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_o_ready", 32'(o_ready), 32'd1);
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic mode, input logic [WIDTH-1:0] d);
        logic acc;
        int   cnt;
        cnt     = 0;
        i_valid = 1'b1;
        i_mode  = mode;
        i_data  = d;
        do begin
            @(negedge i_clk);
            acc = o_ready;
            @(posedge i_clk);
            #1;
            cnt++;
        end while (!acc && cnt < 1000);
        if (!acc) check("accept_timeout", 32'(acc), 32'd1);
        i_valid = 1'b0;
    endtask

    task automatic stop_random_and_drain();
        rand_ready = 1'b0;
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(posedge i_clk);
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int lat;
        int n0;
        int n_acc;
        int n_v;
        logic [WIDTH-1:0] cnt_v;

        do_reset();
        i_ready = 1'b1;

        // Single decode: latency and value.
        send(1'b0, 8'h0B);
        lat = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge i_clk);
            if (o_valid) break;
            lat++;
        end
        check("lat_cycles", 32'(lat), 32'(LATENCY - 1));
        check("lat_data", 32'(o_data), 32'h0D);
        check("lat_mode", 32'(o_mode), 32'd0);
        @(posedge i_clk);
        #1;

        // Encode then decode back to back.
        send(1'b1, 8'h80);
        send(1'b0, 8'hC0);
        repeat (LATENCY - 2) @(posedge i_clk);
        @(negedge i_clk);
        check("b2b_first", 32'({o_valid, o_mode, o_data}), 32'h3C0);
        @(negedge i_clk);
        check("b2b_second", 32'({o_valid, o_mode, o_data}), 32'h280);
        @(posedge i_clk);
        #1;

        // Gray-coded count 0..255 under random backpressure.
        n0 = n_out;
        rand_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            cnt_v = WIDTH'(i);
            send(1'b0, cnt_v ^ (cnt_v >> 1));
        end
        stop_random_and_drain();
        check("stream_count", 32'(n_out - n0), 32'd256);

        // Random mixed-mode traffic with input gaps.
        rand_ready = 1'b1;
        repeat (80) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge i_clk);
                #1;
            end
            send(1'($urandom_range(0, 1)), WIDTH'($urandom));
        end
        stop_random_and_drain();

        // Fill with output stalled, then drain.
        do_reset();
        i_ready = 1'b0;
        i_valid = 1'b1;
        n_acc   = 0;
        repeat (LATENCY + 3) begin
            i_data = WIDTH'($urandom);
            i_mode = 1'($urandom_range(0, 1));
            @(negedge i_clk);
            if (o_ready) n_acc++;
            @(posedge i_clk);
            #1;
        end
        i_valid = 1'b0;
        check("fill_accepts", 32'(n_acc), 32'(LATENCY));
        check("fill_ready_low", 32'(o_ready), 32'd0);
        i_ready = 1'b1;
        n_v = 0;
        repeat (LATENCY) begin
            @(negedge i_clk);
            if (o_valid) n_v++;
        end
        check("drain_burst", 32'(n_v), 32'(LATENCY));
        @(negedge i_clk);
        check("drain_done", 32'(o_valid), 32'd0);
        @(posedge i_clk);
        #1;

        // Reset with two transactions in flight.
        i_ready = 1'b0;
        send(1'b0, WIDTH'($urandom));
        send(1'b1, WIDTH'($urandom));
        do_reset();
        i_ready = 1'b1;
        repeat (6) begin
            @(negedge i_clk);
            check("no_stale", 32'(o_valid), 32'd0);
        end
        @(posedge i_clk);
        #1;

        // Gray-step checker sequence.
        do_reset();
        i_ready = 1'b1;
        send(1'b0, 8'h01);
        send(1'b0, 8'h03);
        send(1'b0, 8'h03);
        repeat (3) @(posedge i_clk);
        #1;
        check("step_legal", 32'(o_step_err), 32'd0);
        send(1'b0, 8'h00);
        check("step_set", 32'(o_step_err), 32'(STEP_EN));
        repeat (5) @(posedge i_clk);
        #1;
        send(1'b0, 8'h01);
        send(1'b1, 8'h55);
        check("step_sticky", 32'(o_step_err), 32'(STEP_EN));
        stop_random_and_drain();
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
